// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store access unit between the MEM pipeline stage and the
//            data memory port. Decodes and checks the request, aligns store
//            data, generates byte enables, runs a ready handshake with a
//            bounded wait and returns sign/zero-extended load data.
// Ports    : iCPU_Clk/iCPU_Reset  - clock, async active-low reset
//            iReq/iWE/iFunct3/iAddr/iWData - request from the MEM stage
//            oStall/oDone/oRData/oFault    - pipeline side results
//            oAB/oWriteData/oByteEn/oRD/oWR, iMemReady/iReadData - memory
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 iCPU_Clk,
    input  logic                 iCPU_Reset,
    input  logic                 iReq,
    input  logic                 iWE,
    input  logic [2:0]           iFunct3,
    input  logic [ADDRWIDTH-1:0] iAddr,
    input  logic [DATAWIDTH-1:0] iWData,
    output logic                 oStall,
    output logic                 oDone,
    output logic [DATAWIDTH-1:0] oRData,
    output logic [1:0]           oFault,
    output logic [ADDRWIDTH-1:0] oAB,
    output logic [DATAWIDTH-1:0] oWriteData,
    output logic [3:0]           oByteEn,
    output logic                 oRD,
    output logic                 oWR,
    input  logic                 iMemReady,
    input  logic [DATAWIDTH-1:0] iReadData
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);
    localparam logic [1:0] c_flt_none  = 2'b00;
    localparam logic [1:0] c_flt_align = 2'b01;
    localparam logic [1:0] c_flt_tmo   = 2'b10;
    localparam logic [1:0] c_flt_f3    = 2'b11;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_we;
    logic [2:0]             r_funct3;
    logic [1:0]             r_lane;
    logic [3:0]             r_be;
    logic [ADDRWIDTH-1:0]   r_ab;
    logic [DATAWIDTH-1:0]   r_wdata;
    logic [DATAWIDTH-1:0]   r_rdata;
    logic [1:0]             r_fault;
    logic [7:0]             r_wait;

    logic                   w_illegal;
    logic                   w_misaligned;
    logic [1:0]             w_req_fault;
    logic [3:0]             w_be;
    logic [DATAWIDTH-1:0]   w_wdata;
    logic [DATAWIDTH-1:0]   w_shifted;
    logic [DATAWIDTH-1:0]   w_load_data;
    logic                   w_timeout;

    // ------------------------------------------------------------------
    // Request decode (from the live request, used only in IDLE)
    // funct3[1:0] is the access size: 00 byte, 01 half, 10 word.
    // ------------------------------------------------------------------
    always_comb begin
        w_illegal = (iFunct3[1:0] == 2'b11);
        if (iWE) begin
            w_illegal = w_illegal | iFunct3[2];
        end else begin
            w_illegal = w_illegal | (iFunct3 == 3'b110);
        end
        w_misaligned = ((iFunct3[1:0] == 2'b01) & iAddr[0]) |
                       ((iFunct3[1:0] == 2'b10) & (|iAddr[1:0]));
        if (w_illegal) begin
            w_req_fault = c_flt_f3;
        end else if (w_misaligned) begin
            w_req_fault = c_flt_align;
        end else begin
            w_req_fault = c_flt_none;
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = iWData;
        case (iFunct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << iAddr[1:0];
                w_wdata = {4{iWData[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << iAddr[1:0];
                w_wdata = {2{iWData[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = iWData;
            end
        endcase
    end

    // Load lane extraction: move the addressed lane down to bit 0 first.
    always_comb begin
        w_shifted = iReadData >> {r_lane, 3'b000};
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
            3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
            default: w_load_data = iReadData;
        endcase
    end

    assign w_timeout = (r_wait == c_wait_last);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (iReq) w_next = (w_req_fault == c_flt_none) ? S_ACCESS : S_RESP;
            S_ACCESS: if (iMemReady || w_timeout) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iCPU_Clk or negedge iCPU_Reset) begin
        if (!iCPU_Reset) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_lane   <= 2'd0;
            r_be     <= 4'd0;
            r_ab     <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_fault  <= c_flt_none;
            r_wait   <= 8'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_wait <= 8'd0;
                    if (iReq) begin
                        r_we     <= iWE;
                        r_funct3 <= iFunct3;
                        r_lane   <= iAddr[1:0];
                        r_be     <= w_be;
                        r_ab     <= {iAddr[ADDRWIDTH-1:2], 2'b00};
                        r_wdata  <= w_wdata;
                        r_fault  <= w_req_fault;
                        r_rdata  <= '0;
                    end
                end
                S_ACCESS: begin
                    if (iMemReady) begin
                        r_rdata <= r_we ? '0 : w_load_data;
                        r_fault <= c_flt_none;
                    end else if (w_timeout) begin
                        // Store counts as not performed; no data returned.
                        r_rdata <= '0;
                        r_fault <= c_flt_tmo;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign oStall     = iReq & (r_state != S_RESP);
    assign oDone      = (r_state == S_RESP);
    assign oRD        = (r_state == S_ACCESS) & ~r_we;
    assign oWR        = (r_state == S_ACCESS) &  r_we;
    assign oByteEn    = (r_state == S_ACCESS) ? r_be : 4'b0000;
    assign oAB        = r_ab;
    assign oWriteData = r_wdata;
    assign oRData     = r_rdata;
    assign oFault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit. Directed scenarios plus
//            randomized requests compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        ready = 1'b0;
    logic [31:0] rdata_in = 32'd0;

    logic        stall, done, rd, wr;
    logic [31:0] rdata_out, ab, wd_out;
    logic [1:0]  fault;
    logic [3:0]  be;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.DATAWIDTH(32), .ADDRWIDTH(32), .TIMEOUT(TMO)) dut (
        .iCPU_Clk   (clk),
        .iCPU_Reset (rst_n),
        .iReq       (req),
        .iWE        (we),
        .iFunct3    (f3),
        .iAddr      (addr),
        .iWData     (wdata),
        .oStall     (stall),
        .oDone      (done),
        .oRData     (rdata_out),
        .oFault     (fault),
        .oAB        (ab),
        .oWriteData (wd_out),
        .oByteEn    (be),
        .oRD        (rd),
        .oWR        (wr),
        .iMemReady  (ready),
        .iReadData  (rdata_in)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] ref_fault(input logic w, input logic [2:0] f, input logic [31:0] a);
        bit legal;
        int nb;
        legal = w ? (f inside {3'd0, 3'd1, 3'd2}) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 2'b11;
        nb = 1 << f[1:0];
        if ((int'(a[1:0]) % nb) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f, input logic [31:0] a);
        int nb;
        nb = 1 << f[1:0];
        return 4'(((1 << nb) - 1) << a[1:0]);
    endfunction

    // Each memory byte lane i carries source byte (i mod access size).
    function automatic logic [31:0] ref_store(input logic [2:0] f, input logic [31:0] d);
        logic [31:0] r;
        int nb;
        nb = 1 << f[1:0];
        r = 32'd0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] word);
        longint v;
        int nb, bits;
        nb = 1 << f[1:0];
        if (nb == 4) return word;
        bits = nb * 8;
        v = longint'(word >> (8 * int'(a[1:0]))) & ((64'sd1 <<< bits) - 1);
        if (!f[2] && (((v >>> (bits - 1)) & 1) == 1)) v = v - (64'sd1 <<< bits);
        return 32'(v);
    endfunction

    // One complete request. rdy_cyc = cycle (counted from the request cycle)
    // in which memory answers; rw = word memory returns then.
    task automatic run_txn(input logic w, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d, input int rdy_cyc, input bit flush,
                           input logic [31:0] rw);
        logic [1:0]  ef, fin_fault;
        logic [31:0] exp_rd;
        int          dcyc;
        ef = ref_fault(w, f, a);
        if (ef != 2'b00)       dcyc = 1;
        else if (rdy_cyc <= TMO) dcyc = rdy_cyc + 1;
        else                   dcyc = TMO + 1;
        fin_fault = (ef != 2'b00) ? ef : ((rdy_cyc <= TMO) ? 2'b00 : 2'b10);
        exp_rd    = (fin_fault == 2'b00 && !w) ? ref_load(f, a, rw) : 32'd0;

        @(posedge clk); #1;
        req = 1'b1; we = w; f3 = f; addr = a; wdata = d; ready = 1'b0; rdata_in = $urandom;
        @(negedge clk);
        check_eq("stall_req", stall, 1);
        check_eq("idle_rd", rd, 0);
        check_eq("idle_done", done, 0);

        for (int c = 1; c <= dcyc; c++) begin
            @(posedge clk); #1;
            ready    = (c == rdy_cyc);
            rdata_in = (c == rdy_cyc) ? rw : $urandom;
            if (flush && c >= 2) req = 1'b0;
            @(negedge clk);
            if (c < dcyc) begin
                check_eq("acc_rd", rd, !w);
                check_eq("acc_wr", wr, w);
                check_eq("acc_be", be, ref_be(f, a));
                check_eq("acc_ab", ab, {a[31:2], 2'b00});
                if (w) check_eq("acc_wdata", wd_out, ref_store(f, d));
                check_eq("acc_done", done, 0);
                check_eq("acc_stall", stall, req);
            end else begin
                check_eq("resp_done", done, 1);
                check_eq("resp_stall", stall, 0);
                check_eq("resp_rd_wr", {rd, wr}, 0);
                check_eq("resp_fault", fault, fin_fault);
                if (!w || fin_fault != 2'b00) check_eq("resp_rdata", rdata_out, exp_rd);
            end
        end

        // Following cycle: pipeline moved on, stray iMemReady must be ignored.
        @(posedge clk); #1;
        req = 1'b0; ready = 1'b1;
        @(negedge clk);
        check_eq("post_done", done, 0);
        check_eq("post_strobes", {rd, wr, be}, 0);
        check_eq("post_stall", stall, 0);
        @(posedge clk); #1;
        ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        req = 1'b1;
        #12;
        check_eq("rst_stall", stall, 1);
        check_eq("rst_outs", {done, rd, wr, be, fault}, 0);
        check_eq("rst_ab", ab, 0);
        check_eq("rst_rdata", rdata_out, 0);
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed scenarios
        run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 1, 1'b0, 32'h80FF_1234); // LB
        run_txn(1'b0, 3'b100, 32'h0000_0103, 32'h0, 1, 1'b0, 32'h80FF_1234); // LBU
        run_txn(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 4, 1'b0, 32'h0);  // SH, 3 waits
        run_txn(1'b0, 3'b010, 32'h0000_0101, 32'h0, 1, 1'b0, 32'hDEAD_BEEF);  // LW misaligned
        run_txn(1'b0, 3'b011, 32'h0000_0000, 32'h0, 1, 1'b0, 32'hDEAD_BEEF);  // illegal
        run_txn(1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 99, 1'b0, 32'h0); // SW timeout
        run_txn(1'b0, 3'b010, 32'h0000_0010, 32'h0, TMO, 1'b0, 32'h1357_9BDF); // last-chance ready
        run_txn(1'b0, 3'b101, 32'h0000_0002, 32'h0, 1, 1'b0, 32'h8001_0000); // LHU
        run_txn(1'b0, 3'b001, 32'h0000_0002, 32'h0, 1, 1'b0, 32'h8001_0000); // LH
        run_txn(1'b0, 3'b010, 32'h0000_0040, 32'h0, 3, 1'b1, 32'h0BAD_F00D); // flush

        // Reset in the middle of a slow load
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h0000_0080; ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("pre_rst_rd", rd, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rd", rd, 0);
        check_eq("mid_rst_outs", {done, wr, be, fault}, 0);
        check_eq("mid_rst_ab", ab, 0);
        check_eq("mid_rst_wd", wd_out, 0);
        check_eq("mid_rst_rdata", rdata_out, 0);
        check_eq("mid_rst_stall", stall, 1);
        @(posedge clk); #1;
        req = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_done", done, 0);
        run_txn(1'b1, 3'b010, 32'h0000_0444, 32'hA5A5_5A5A, 2, 1'b0, 32'h0);

        // Randomized requests
        for (int i = 0; i < 60; i++) begin
            run_txn(1'($urandom), 3'($urandom), $urandom, $urandom,
                    $urandom_range(1, TMO + 2), ($urandom % 4) == 0, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store access unit placed between the CPU's MEM pipeline stage and the data memory port. It accepts one load or store per request, aligns store data and generates byte enables, runs a ready-based handshake toward memory with a bounded wait, and returns sign- or zero-extended load data. It holds the pipeline stalled until the access completes or faults.

## Interface
Parameters:
- DATAWIDTH, 32: data bus width; only 32 is supported.
- ADDRWIDTH, 32: address width.
- TIMEOUT, 16: maximum number of ACCESS cycles to wait for iMemReady. Legal range 2..255.

Ports:
- iCPU_Clk  in  1  single clock; all state updates on the rising edge.
- iCPU_Reset  in  1  asynchronous, active-low reset.
- iReq  in  1  MEM stage holds a load/store. Level signal, held until oDone.
- iWE  in  1  1 = store, 0 = load.
- iFunct3  in  3  RISC-V funct3 of the load/store.
- iAddr  in  ADDRWIDTH  byte address (ALU result).
- iWData  in  DATAWIDTH  store source register value.
- oStall  out  1  freeze IF/ID/EX/MEM pipeline registers.
- oDone  out  1  one-cycle completion pulse.
- oRData  out  DATAWIDTH  extended load result, valid while oDone=1.
- oFault  out  2  valid while oDone=1: 00 none, 01 misaligned, 10 timeout, 11 illegal funct3.
- oAB  out  ADDRWIDTH  word-aligned memory address (iAddr with [1:0] cleared).
- oWriteData  out  DATAWIDTH  lane-replicated store data.
- oByteEn  out  4  byte-lane enables; bit i covers bits [8i+7:8i].
- oRD, oWR  out  1  memory read and write strobes.
- iMemReady  in  1  memory completes the access in this cycle.
- iReadData  in  DATAWIDTH  memory read word, sampled when iMemReady=1.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE behaviour:
  - If iReq=1, the unit latches iWE, iFunct3, iAddr and iWData.
  - If the request is legal and aligned, next state is ACCESS.
  - Otherwise next state is RESP with the fault code latched.
- ACCESS behaviour:
  - oRD = ~we and oWR = we, both held for the whole state.
  - oAB, oByteEn and oWriteData are driven from registered values and are stable throughout the state.
  - iMemReady=1: capture iReadData, next state is RESP with fault 00.
  - A wait counter counts ACCESS cycles. If iMemReady is still 0 after TIMEOUT cycles, next state is RESP with fault 10. No data is captured and a store is treated as not performed.
- RESP behaviour: oDone=1 and oStall=0 for exactly one cycle, then return to IDLE unconditionally.
- oStall = iReq & (state != RESP). This is combinational, so the stall is asserted in the same cycle the request appears.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value gives fault 11.
- Alignment: halfword accesses require addr[0]=0; word accesses require addr[1:0]=00. A violation gives fault 01. Illegal funct3 takes priority over misalignment.
- Byte enables:
  - Byte access: 0001 << addr[1:0].
  - Halfword access: 0011 << addr[1:0].
  - Word access: 1111.
  - Loads use the same enables.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata unchanged.
- Load data:
  - The lane is selected by addr[1:0].
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - LW passes the word unchanged.
- On any fault, oRData = 0.
- Outside ACCESS: oRD = oWR = 0 and oByteEn = 0000. oAB and oWriteData hold their last values.

## Timing
- Reset (asynchronous, active-low) is applied immediately, including mid-ACCESS:
  - state goes to IDLE;
  - oRD, oWR, oDone = 0;
  - oByteEn = 0000, oFault = 00;
  - oRData, oAB, oWriteData = 0;
  - the wait counter is cleared.
- oStall follows iReq during reset, since the pipeline registers are also in reset.
- Zero-wait memory (iReq at cycle 0, iMemReady=1 in cycle 1): ACCESS in cycle 1, RESP/oDone in cycle 2. That is 2 stall cycles.
- With N wait cycles (iMemReady first high in ACCESS cycle N+1), oDone occurs at cycle N+2.
- Fault detected in IDLE: RESP in cycle 1, giving 1 stall cycle and no memory strobe.
- Timeout: ACCESS spans cycles 1..TIMEOUT, and oDone is at cycle TIMEOUT+1.
- The pipeline advances at the end of the RESP cycle. An iReq seen in the cycle after RESP is a new request; back-to-back requests never overlap.
- iMemReady outside ACCESS is ignored.
- iReq dropping during ACCESS (flush) does not abort the access: it completes and oDone still pulses once.

## Test plan
- LB and LBU at iAddr=0x0000_0103, iReadData=0x80FF_1234, zero wait -> oAB=0x0000_0100, oByteEn=1000, oRD=1 in cycle 1; oDone in cycle 2 with oRData=0xFFFF_FF80 (LB) and 0x0000_0080 (LBU), oFault=00.
- SH at iAddr=0x0000_0202, iWData=0x1234_ABCD, iMemReady after 3 wait cycles -> oWR=1 for 4 cycles, oWriteData=0xABCD_ABCD, oByteEn=1100, oAB=0x0000_0200; oDone at cycle 5; oStall high cycles 0..4.
- LW at iAddr=0x0000_0101 -> no oRD/oWR, oDone at cycle 1 with oFault=01, oRData=0; a load with iFunct3=011 -> oFault=11.
- TIMEOUT=8, SW with iMemReady held at 0 -> oWR high for cycles 1..8, oDone at cycle 9 with oFault=10; iMemReady pulsed in cycle 10 causes no effect.
- LHU at iAddr=0x0000_0002, iReadData=0x8001_0000 -> oRData=0x0000_8001; LH at the same address -> 0xFFFF_8001.
- Assert reset in cycle 2 of a 5-wait-cycle load -> oRD falls immediately, all outputs zero, no oDone; after release, a new SW completes normally.
